// File: rtl/lcd_cmd_scheduler.sv
// lcd_cmd_scheduler: FIFO-buffered host command sequencer for the LCD cmd/busy handshake; LCD_SCHED_SKIP_EN drops no-op shifts
module lcd_cmd_scheduler #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  in_cmd,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [3:0]  lcd_cmd,
  output logic        lcd_cmd_valid,
  input  logic        lcd_busy,
  input  logic        lcd_done,
  output logic        retire_valid,
  output logic [3:0]  retire_cmd,
  output logic        retire_skipped,
  output logic [AW:0] fifo_count,
  output logic        sched_idle,
  output logic        err_illegal
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, RUN} state_t;
  state_t        state_q, state_d;
  logic [3:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   count_q;
  logic [3:0]    cur_q, head;
  logic          err_q, legal, accept, push, pop, issue, skip;
  logic          unused_done;
  assign unused_done = lcd_done;
  assign head        = mem_q[rd_q];
  assign legal       = in_cmd < 4'hC;
  assign in_ready    = ~count_q[AW];
  assign accept      = in_valid & in_ready;
  assign push        = accept & legal;
  assign pop         = (state_q == IDLE) & (count_q != '0) & ~lcd_busy;
  assign issue       = pop & ~skip;
  assign lcd_cmd     = cur_q;
  assign fifo_count  = count_q;
  assign err_illegal = err_q;
  assign sched_idle  = (count_q == '0) & (state_q == IDLE) & ~lcd_busy;
`ifdef LCD_SCHED_SKIP_EN
  logic [2:0] x_q, y_q;
  assign skip = pop & ((head == 4'h1 && y_q == 3'd0) | (head == 4'h2 && y_q == 3'd6) |
                       (head == 4'h3 && x_q == 3'd0) | (head == 4'h4 && x_q == 3'd6));
  // Track the LCD window origin; a skip never issues, so an issued shift always moves
  always_ff @(posedge clk) begin
    if (reset) begin
      x_q <= 3'd3;
      y_q <= 3'd3;
    end else if (issue) begin
      if (head == 4'h1) y_q <= y_q - 3'd1;
      if (head == 4'h2) y_q <= y_q + 3'd1;
      if (head == 4'h3) x_q <= x_q - 3'd1;
      if (head == 4'h4) x_q <= x_q + 3'd1;
    end
  end
`else
  assign skip = 1'b0;
`endif
  // FIFO storage needs no reset; occupancy is tracked by count_q
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= in_cmd;
  end
  // State, FIFO pointers/count, current command and sticky illegal flag
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      cur_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (push) wr_q <= wr_q + 1'b1;
      if (pop) rd_q <= rd_q + 1'b1;
      count_q <= count_q + (AW+1)'(push) - (AW+1)'(pop);
      if (issue) cur_q <= head;
      if (accept & ~legal) err_q <= 1'b1;
    end
  end
  // Next state and handshake/retire strobes
  always_comb begin
    state_d        = state_q;
    lcd_cmd_valid  = 1'b0;
    retire_valid   = skip;
    retire_skipped = skip;
    retire_cmd     = skip ? head : cur_q;
    case (state_q)
      IDLE:     state_d = issue ? ISSUE : IDLE;
      ISSUE: begin
        lcd_cmd_valid = 1'b1;
        state_d       = WAIT_ACK;
      end
      WAIT_ACK: state_d = lcd_busy ? RUN : WAIT_ACK;
      RUN: begin
        retire_valid = ~lcd_busy;
        state_d      = lcd_busy ? RUN : IDLE;
      end
      default:  state_d = IDLE;
    endcase
  end
endmodule

// File: doc/lcd_cmd_scheduler.md
# lcd_cmd_scheduler

Command front-end for the image display controller. Buffers host commands in a small FIFO and sequences them one at a time into the LCD controller's `cmd`/`cmd_valid`/`busy` handshake. It holds `cmd` stable for the whole busy window and reports each retired command back to the host. It sits between the host/testbench command source and the LCD controller, and adds no change to the datapath itself.

## Interface
Parameters:
- `DEPTH`, 8: FIFO entries; power of two, ≥2.
- `AW`, 3: log2(DEPTH).

Ports:
- `clk`  in  1  single clock, all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `in_cmd`  in  4  host command, 0x0–0xB legal.
- `in_valid`  in  1  host offers `in_cmd`.
- `in_ready`  out  1  FIFO can accept; transfer on `in_valid & in_ready`.
- `lcd_cmd`  out  4  command to LCD controller.
- `lcd_cmd_valid`  out  1  one-cycle issue strobe.
- `lcd_busy`  in  1  LCD controller busy.
- `lcd_done`  in  1  LCD controller write-out done flag.
- `retire_valid`  out  1  one-cycle pulse per completed or skipped command.
- `retire_cmd`  out  4  command being retired.
- `retire_skipped`  out  1  qualifies `retire_valid`: command was not issued.
- `fifo_count`  out  AW+1  current FIFO occupancy.
- `sched_idle`  out  1  FIFO empty, FSM in IDLE, and `lcd_busy`=0.
- `err_illegal`  out  1  sticky: an illegal command (0xC–0xF) was offered and dropped.

## Operation
- **Reset values:** all outputs are 0 except `in_ready`=1. FSM goes to IDLE and the FIFO empties. The tracked window position is (x=3, y=3), matching the LCD controller reset origin 27. Reset mid-command abandons the command, with no retire pulse.
- **FIFO:** circular, `DEPTH` entries.
  - `in_ready` = (`fifo_count` < DEPTH), computed from the registered count. A same-cycle pop does not allow a push when full.
  - Illegal codes are handshaked (consumed) but not stored, and they set `err_illegal`. Only reset clears it.
  - Simultaneous push and pop leaves the count unchanged.
- **FSM states:**
  - **IDLE:** if count≠0 and `lcd_busy`=0, pop the head into `cur_cmd` and go to ISSUE. Otherwise stay.
  - **ISSUE:** `lcd_cmd_valid`=1 for exactly this cycle, then go to WAIT_ACK.
  - **WAIT_ACK:** wait for `lcd_busy`=1, then go to RUN. There is no timeout.
  - **RUN:** when `lcd_busy`=0, pulse `retire_valid` with `retire_cmd`=`cur_cmd`, then go to IDLE.
- **`lcd_cmd`:** equals `cur_cmd` in ISSUE, WAIT_ACK and RUN, because the LCD controller re-samples `cmd` every busy cycle. In IDLE it holds its last value.
- **Initial load:** the LCD controller holds `lcd_busy`=1 after reset while it loads the image from ROM. IDLE blocks issue until busy falls, and commands still queue meanwhile.
- **Write (0x0):** retires when busy falls after 64 output cycles; `lcd_done` is then 1. A later Write is issued normally.
- **Window position:** updated at the ISSUE transition for 0x1–0x4.
  - 0x1 (up): y−1 if y>0.
  - 0x2 (down): y+1 if y<6.
  - 0x3 (left): x−1 if x>0.
  - 0x4 (right): x+1 if x<6.
  - Other commands leave the position unchanged.

## Timing
- From the acceptance edge, with an empty FIFO, IDLE state and busy low: `lcd_cmd_valid` is high in the 2nd cycle after the edge (1 cycle FIFO write, 1 cycle pop).
- **Shift/rotate/mirror:** the LCD controller is busy for 1 cycle. Retire occurs 3 cycles after ISSUE: ISSUE → WAIT_ACK → RUN(busy=1) → RUN(busy=0, retire).
- **Max/Min/Average:** busy for 3 cycles; the retire pulse follows in the first cycle busy is seen low.
- **Back-to-back:** a one-cycle IDLE gap sits between a retire and the next ISSUE.
- `retire_valid` and `lcd_cmd_valid` are never high in the same cycle.

## Configuration
- `LCD_SCHED_SKIP_EN` defined: in IDLE, a popped shift that would be a no-op at the current position is not issued. Examples: 0x1 with y=0, or 0x4 with x=6. The FSM stays in IDLE and pulses `retire_valid` with `retire_skipped`=1 in the pop cycle, allowing one skip per cycle.
- Not defined: every legal command is issued, `retire_skipped` is tied to 0, and position tracking logic is omitted.

## Test plan
- **Reset/load:** hold `lcd_busy`=1 for 130 cycles after reset, pushing 0x5, 0x0 meanwhile → no `lcd_cmd_valid` until busy falls. 0x5 issues first and retires after 3 busy cycles, then 0x0 issues and retires with `lcd_done`=1.
- **Full FIFO:** with DEPTH=8 and busy stuck high, push 9 commands → `in_ready`=0 after 8 and `fifo_count`=8. Release busy → all 8 retire in push order.
- **Illegal:** push 0xD between 0x3 and 0x4 → only 0x3 and 0x4 are issued, and `err_illegal`=1 persists until reset.
- **Cmd hold:** issue 0x7 with a 3-cycle busy → `lcd_cmd`=0x7 on every busy cycle and `retire_cmd`=0x7 once.
- **Skip (`LCD_SCHED_SKIP_EN`):** push 0x1 ×4 → three issued, then the 4th retires with `retire_skipped`=1 and no `lcd_cmd_valid`. Without the macro, all 4 are issued.
- **Reset mid-RUN:** assert `reset` during the Average busy window → the next cycle has `lcd_cmd_valid`=0, `fifo_count`=0, no `retire_valid`, and `in_ready`=1.
